ram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one 64x8 single-port synchronous RAM, whose address is registered and whose read data is combinational from that address. It drives the RAM's data, address, write-enable and read-data interface. Requesters use a valid/ready request channel and receive read data on a response channel one cycle after the grant. Arbitration is round-robin, with an optional bounded burst lock.

---
 rtl/ram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port arbiter for a 64x8 single-port RAM with bounded burst lock
// Optional per-requester grant counters are enabled by defining RAM_ARB_STATS_EN.
module ram_port_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam bit LOCK_EN = (MAX_BURST > 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t           r_state;
  logic             r_prio;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;

  logic             w_own0;
  logic             w_own1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_own_lock;

  // A lock whose owner drops valid lapses and falls through to the idle arbitration.
  always_comb begin
    w_own0 = (r_state == LOCK0) && req0_valid;
    w_own1 = (r_state == LOCK1) && req1_valid;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_own0) begin
      w_gnt0 = 1'b1;
    end else if (w_own1) begin
      w_gnt1 = 1'b1;
    end else if (req0_valid && req1_valid) begin
      w_gnt0 = !r_prio;
      w_gnt1 = r_prio;
    end else begin
      w_gnt0 = req0_valid;
      w_gnt1 = req1_valid;
    end
  end

  assign w_cnt_inc  = r_burst_cnt + CNT_W'(1);
  assign w_own_lock = w_own0 ? req0_lock : req1_lock;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign ram_we     = (w_gnt0 && req0_we) || (w_gnt1 && req1_we);
  assign ram_addr   = w_gnt1 ? req1_addr : req0_addr;
  assign ram_data   = w_gnt1 ? req1_wdata : req0_wdata;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = ram_q;
  assign rsp1_data  = ram_q;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prio       <= 1'b0;
      r_burst_cnt  <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= w_gnt0 && !req0_we;
      r_rsp1_valid <= w_gnt1 && !req1_we;
      if (w_own0 || w_own1) begin
        if (!w_own_lock || (w_cnt_inc >= MAX_CNT)) begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
          if (w_cnt_inc >= MAX_CNT) r_prio <= w_own0;
        end else begin
          r_burst_cnt <= w_cnt_inc;
        end
      end else if (w_gnt0) begin
        r_prio <= 1'b1;
        if (req0_lock && LOCK_EN) begin
          r_state     <= LOCK0;
          r_burst_cnt <= CNT_W'(1);
        end else begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      end else if (w_gnt1) begin
        r_prio <= 1'b0;
        if (req1_lock && LOCK_EN) begin
          r_state     <= LOCK1;
          r_burst_cnt <= CNT_W'(1);
        end else begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      end else begin
        r_state     <= IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_gnt1 && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
  logic [5:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
  logic [5:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;
  logic       ram_we, busy;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  // RAM: registered address (captured on reads only), combinational q.
  logic [7:0] mem [64];
  logic [5:0] r_a = '0;
  initial for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h3C;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        r_a <= ram_addr;
  end
  assign ram_q = mem[r_a];

  ram_port_arbiter #(.DATA_W(8), .ADDR_W(6), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
`ifdef RAM_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d, input logic l);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_lock = l;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d, input logic l);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_lock = l;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [5:0] g0_exp;
    logic [5:0] busy_exp;
    g0_exp   = 6'b101111;
    busy_exp = 6'b001110;

    #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_rsp0", rsp0_valid, 0);
    check("rst_rsp1", rsp1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_we", ram_we, 0);
    step();
    do_reset();

    // write 0xA5 to 5, then read it back
    drv0(1, 1, 6'd5, 8'hA5, 0); #2;
    check("wr_ready0", req0_ready, 1);
    check("wr_ready1", req1_ready, 0);
    check("wr_we", ram_we, 1);
    check("wr_addr", ram_addr, 5);
    check("wr_data", ram_data, 8'hA5);
    step();
    drv0(1, 0, 6'd5, 8'h00, 0); #2;
    check("rd_ready0", req0_ready, 1);
    check("rd_we", ram_we, 0);
    check("wr_no_rsp", rsp0_valid, 0);
    step();
    drv0(0, 0, 6'd0, 8'h00, 0); #2;
    check("rd_rsp0_valid", rsp0_valid, 1);
    check("rd_rsp0_data", rsp0_data, 8'hA5);
    check("rd_rsp1_quiet", rsp1_valid, 0);
    step();

    // prio returns to 0 after reset; alternation under contention
    do_reset();
    drv0(1, 0, 6'd10, 8'h00, 0);
    drv1(1, 0, 6'd20, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_ready0", req0_ready, (i % 2) == 0);
      check("rr_ready1", req1_ready, (i % 2) == 1);
      if (i > 0) begin
        check("rr_rsp0_valid", rsp0_valid, (i % 2) == 1);
        check("rr_rsp1_valid", rsp1_valid, (i % 2) == 0);
        check("rr_rsp_data", ram_q, ((i % 2) == 1) ? 8'h36 : 8'h28);
      end
      step();
    end
    drv0(0, 0, 6'd0, 8'h00, 0);
    drv1(0, 0, 6'd0, 8'h00, 0); #2;
    check("rr_last_rsp1", rsp1_valid, 1);
    check("rr_last_data1", rsp1_data, 8'h28);
    check("rr_last_rsp0", rsp0_valid, 0);
    step();

    // req0 burst lock bounded at 4 beats against a competing req1
    drv0(1, 0, 6'd3, 8'h00, 1);
    drv1(1, 0, 6'd4, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      #2;
      check("lk_ready0", req0_ready, g0_exp[i]);
      check("lk_ready1", req1_ready, !g0_exp[i]);
      check("lk_busy", busy, busy_exp[i]);
      step();
    end
    drv0(0, 0, 6'd0, 8'h00, 0);
    drv1(0, 0, 6'd0, 8'h00, 0); #2;
    check("lk_relock_busy", busy, 1);
    check("lk_idle_ready0", req0_ready, 0);
    step(); #2;
    check("lk_lapse_busy", busy, 0);
    step();

    // req1 lock lapses, req0 served in the same cycle
    drv1(1, 0, 6'd7, 8'h00, 1); #2;
    check("lp_ready1_a", req1_ready, 1);
    check("lp_busy_a", busy, 0);
    step();
    drv0(1, 0, 6'd8, 8'h00, 0); #2;
    check("lp_ready1_b", req1_ready, 1);
    check("lp_ready0_b", req0_ready, 0);
    check("lp_busy_b", busy, 1);
    check("lp_rsp1_b", rsp1_valid, 1);
    check("lp_rsp1_data_b", rsp1_data, 8'h3B);
    step();
    drv1(0, 0, 6'd0, 8'h00, 0); #2;
    check("lp_ready0_c", req0_ready, 1);
    check("lp_ready1_c", req1_ready, 0);
    check("lp_busy_c", busy, 1);
    step();
    drv0(0, 0, 6'd0, 8'h00, 0); #2;
    check("lp_busy_d", busy, 0);
    check("lp_rsp0_d", rsp0_valid, 1);
    check("lp_rsp0_data_d", rsp0_data, 8'h34);
    step();

    // asynchronous reset the cycle after a locked read grant to req1
    drv1(1, 0, 6'd9, 8'h00, 1); #2;
    check("ar_ready1", req1_ready, 1);
    step();
    drv1(0, 0, 6'd0, 8'h00, 0); #1;
    check("ar_pre_rsp1", rsp1_valid, 1);
    check("ar_pre_busy", busy, 1);
    rst = 1'b1; #1;
    check("ar_rsp1", rsp1_valid, 0);
    check("ar_busy", busy, 0);
    step();
    rst = 1'b0;
    drv0(1, 0, 6'd1, 8'h00, 0);
    drv1(1, 0, 6'd2, 8'h00, 0); #2;
    check("ar_first_ready0", req0_ready, 1);
    check("ar_first_ready1", req1_ready, 0);
    check("ar_no_rsp1", rsp1_valid, 0);
    step();
    drv0(0, 0, 6'd0, 8'h00, 0);
    drv1(0, 0, 6'd0, 8'h00, 0);
    step();

`ifdef RAM_ARB_STATS_EN
    do_reset(); #2;
    check("st_rst0", grant_cnt0, 0);
    check("st_rst1", grant_cnt1, 0);
    drv0(1, 0, 6'd1, 8'h00, 0);
    drv1(1, 0, 6'd2, 8'h00, 0);
    for (int i = 0; i < 4; i++) step();
    drv1(0, 0, 6'd0, 8'h00, 0);
    step();
    drv0(0, 0, 6'd0, 8'h00, 0); #2;
    check("st_cnt0", grant_cnt0, 3);
    check("st_cnt1", grant_cnt1, 2);
    do_reset(); #2;
    check("st_clr0", grant_cnt0, 0);
    check("st_clr1", grant_cnt1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
